// File: rtl/lsu_ctrl.sv
// Load/store unit: steers byte lanes and enables toward a req/ack data memory,
// formats load data, rejects misaligned word accesses and bounds the ack wait.
module lsu_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lsu_vld,
    output logic              o_lsu_rdy,
    input  logic              i_mem_rden,
    input  logic              i_mem_wren,
    input  logic              i_w_b_LSU,
    input  logic              i_l_unsigned,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic [31:0]       o_rdata,
    output logic              o_rdata_vld,
    output logic              o_misalign,
    output logic              o_timeout,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [3:0]        o_dmem_be,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_ack,
    input  logic [31:0]       i_dmem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    // Expiry is the cycle in which the counter holds TIMEOUT_CYC-1 (the TIMEOUT_CYC-th REQ cycle).
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          lane_q, lane_d;
    logic                byte_q, byte_d;
    logic                uns_q, uns_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                mis_q, mis_d;
    logic                to_q, to_d;

    logic                op_req;
    logic                misaligned;
    logic                accept;
    logic                expire;
    logic [7:0]          sel_byte;
    logic [31:0]         fmt_data;

    assign op_req     = i_lsu_vld & (i_mem_rden | i_mem_wren);
    assign misaligned = ~i_w_b_LSU & (i_addr[1:0] != 2'b00);
    assign accept     = (state_q == IDLE) & op_req & ~misaligned;
    assign expire     = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

    assign sel_byte = i_dmem_rdata[{lane_q, 3'b000} +: 8];
    assign fmt_data = !byte_q ? i_dmem_rdata :
                      uns_q   ? {24'h000000, sel_byte} :
                                {{24{sel_byte[7]}}, sel_byte};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            byte_q  <= 1'b0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            byte_q  <= byte_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        byte_d  = byte_q;
        uns_d   = uns_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        to_d    = to_q;

        case (state_q)
            IDLE: begin
                if (op_req && misaligned) begin
                    mis_d = 1'b1;
                end else if (accept) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
                    lane_d  = i_addr[1:0];
                    byte_d  = i_w_b_LSU;
                    uns_d   = i_l_unsigned;
                    we_d    = i_mem_wren;
                    to_d    = 1'b0;
                    if (i_w_b_LSU) begin
                        be_d    = 4'b0001 << i_addr[1:0];
                        wdata_d = {4{i_wdata[7:0]}};
                    end else begin
                        be_d    = 4'hF;
                        wdata_d = i_wdata;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                // Ack takes priority over a coincident expiry.
                if (i_dmem_ack) begin
                    if (!we_q) rdata_d = fmt_data;
                    state_d = DONE;
                end else if (expire) begin
                    if (!we_q) rdata_d = '0;
                    to_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_lsu_rdy    = i_rst_n & (state_q == IDLE);
    assign o_stall      = i_rst_n & (accept | (state_q == REQ));
    assign o_dmem_req   = (state_q == REQ);
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_be    = be_q;
    assign o_dmem_wdata = wdata_q;
    assign o_rdata      = rdata_q;
    assign o_rdata_vld  = (state_q == DONE) & ~we_q;
    assign o_timeout    = (state_q == DONE) & to_q;
    assign o_misalign   = mis_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed table-driven bench for lsu_ctrl (TIMEOUT_CYC = 4) plus reset and stray-ack sequences.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        lsu_vld;
    logic        lsu_rdy;
    logic        mem_rden;
    logic        mem_wren;
    logic        w_b;
    logic        l_uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_vld;
    logic        misalign;
    logic        timeout;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int errors = 0;
    int checks = 0;

    lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_lsu_vld    (lsu_vld),
        .o_lsu_rdy    (lsu_rdy),
        .i_mem_rden   (mem_rden),
        .i_mem_wren   (mem_wren),
        .i_w_b_LSU    (w_b),
        .i_l_unsigned (l_uns),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall),
        .o_rdata      (rdata),
        .o_rdata_vld  (rdata_vld),
        .o_misalign   (misalign),
        .o_timeout    (timeout),
        .o_dmem_req   (dmem_req),
        .o_dmem_we    (dmem_we),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_be    (dmem_be),
        .o_dmem_wdata (dmem_wdata),
        .i_dmem_ack   (dmem_ack),
        .i_dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rden;
        logic        wren;
        logic        byte_op;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_at;      // REQ cycle carrying the ack; 0 = never
        logic [31:0] mem_rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic [31:0] exp_rdata;
        logic        exp_vld;
        logic        exp_mis;
        logic        exp_to;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n_req;
        int exp_req;
        @(posedge clk); #1;
        lsu_vld  = 1'b1;
        mem_rden = v.rden;
        mem_wren = v.wren;
        w_b      = v.byte_op;
        l_uns    = v.uns;
        addr     = v.addr;
        wdata    = v.wdata;
        @(negedge clk);
        check({tag, "_rdy_T"}, 32'(lsu_rdy), 32'd1);
        check({tag, "_stall_T"}, 32'(stall), 32'(!v.exp_mis));
        @(posedge clk); #1;
        lsu_vld  = 1'b0;
        mem_rden = 1'b0;
        mem_wren = 1'b0;
        if (v.exp_mis) begin
            @(negedge clk);
            check({tag, "_mis_pulse"}, 32'(misalign), 32'd1);
            check({tag, "_mis_req"}, 32'(dmem_req), 32'd0);
            check({tag, "_mis_stall"}, 32'(stall), 32'd0);
            check({tag, "_mis_rdy"}, 32'(lsu_rdy), 32'd1);
            @(negedge clk);
            check({tag, "_mis_end"}, 32'(misalign), 32'd0);
            check({tag, "_mis_req2"}, 32'(dmem_req), 32'd0);
        end else begin
            n_req = 0;
            for (int k = 1; k <= 8; k++) begin
                dmem_ack   = (k == v.ack_at);
                dmem_rdata = v.mem_rdata;
                @(negedge clk);
                if (!dmem_req) break;
                n_req++;
                check({tag, "_stall_req"}, 32'(stall), 32'd1);
                if (k == 1) begin
                    check({tag, "_addr"}, dmem_addr, v.exp_addr);
                    check({tag, "_be"}, 32'(dmem_be), 32'(v.exp_be));
                    check({tag, "_we"}, 32'(dmem_we), 32'(v.exp_we));
                    if (v.exp_we) check({tag, "_wdata"}, dmem_wdata, v.exp_wdata);
                end
                @(posedge clk); #1;
                dmem_ack = 1'b0;
            end
            dmem_ack = 1'b0;
            exp_req = (v.ack_at != 0) ? v.ack_at : 4;
            check({tag, "_req_cycles"}, 32'(n_req), 32'(exp_req));
            check({tag, "_done_stall"}, 32'(stall), 32'd0);
            check({tag, "_done_rdy"}, 32'(lsu_rdy), 32'd0);
            check({tag, "_done_vld"}, 32'(rdata_vld), 32'(v.exp_vld));
            check({tag, "_done_to"}, 32'(timeout), 32'(v.exp_to));
            if (v.exp_vld) check({tag, "_rdata"}, rdata, v.exp_rdata);
            @(negedge clk);
            check({tag, "_idle_rdy"}, 32'(lsu_rdy), 32'd1);
            check({tag, "_idle_vld"}, 32'(rdata_vld), 32'd0);
        end
    endtask

    initial begin
        //           rden  wren  byte  uns   addr          wdata         ack mem_rdata     exp_addr      be       exp_wdata     we    exp_rdata     vld   mis   to
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000010, 32'h0,        3, 32'hDEADBEEF, 32'h00000010, 4'hF,    32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00000013, 32'h0,        2, 32'h80112233, 32'h00000010, 4'b1000, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00000013, 32'h0,        2, 32'h80112233, 32'h00000010, 4'b1000, 32'h0,        1'b0, 32'h00000080, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00000021, 32'h000000A5, 1, 32'h0,        32'h00000020, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000006, 32'h0,        1, 32'h0,        32'h0,        4'h0,    32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000040, 32'h0,        0, 32'h55555555, 32'h00000040, 4'hF,    32'h0,        1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000044, 32'h0,        4, 32'h12345678, 32'h00000044, 4'hF,    32'h0,        1'b0, 32'h12345678, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000008, 32'hCAFEF00D, 1, 32'h0,        32'h00000008, 4'hF,    32'hCAFEF00D, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00000005, 32'h0,        1, 32'h00007F00, 32'h00000004, 4'b0010, 32'h0,        1'b0, 32'h0000007F, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000000C, 32'h01020304, 2, 32'hFFFFFFFF, 32'h0000000C, 4'hF,    32'h01020304, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00000030, 32'h12345699, 1, 32'h0,        32'h00000030, 4'b0001, 32'h99999999, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0};

        rst_n      = 1'b0;
        lsu_vld    = 1'b0;
        mem_rden   = 1'b0;
        mem_wren   = 1'b0;
        w_b        = 1'b0;
        l_uns      = 1'b0;
        addr       = '0;
        wdata      = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;

        #12;
        check("rst_rdy", 32'(lsu_rdy), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_vld", 32'(rdata_vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rdy", 32'(lsu_rdy), 32'd1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Stray ack while idle must not produce a result or touch o_rdata.
        @(posedge clk); #1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBADBAD00;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check("stray_vld", 32'(rdata_vld), 32'd0);
        check("stray_rdata", rdata, 32'h0000007F);
        check("stray_rdy", 32'(lsu_rdy), 32'd1);

        // Reset asserted in the middle of a REQ wait.
        @(posedge clk); #1;
        lsu_vld  = 1'b1;
        mem_rden = 1'b1;
        w_b      = 1'b0;
        addr     = 32'h00000080;
        @(posedge clk); #1;
        lsu_vld  = 1'b0;
        mem_rden = 1'b0;
        @(posedge clk); #1;
        check("mid_req_before", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(dmem_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_rdy", 32'(lsu_rdy), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("after_rst_strobes", {29'd0, rdata_vld, timeout, misalign}, 32'd0);
        end
        check("after_rst_rdy", 32'(lsu_rdy), 32'd1);
        run_vec(vecs[0], "after_rst_lw");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit that executes the memory requests decoded by the control unit: mem_rden, mem_wren, w_b_LSU (byte/word) and l_unsigned.
- Sits between the execute stage (ALU result as address, rs2 as store data) and a data memory that uses a req/ack handshake with variable latency.
- Handles byte-lane steering, byte enables, load sign/zero extension, misalignment detection, pipeline stall and an ack timeout.

Parameters:
- ADDR_W, 32, byte-address width presented to data memory.
- TIMEOUT_CYC, 16, maximum cycles spent waiting for i_dmem_ack; 0 disables the timeout.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_lsu_vld  in  1  core presents a memory op this cycle.
- o_lsu_rdy  out  1  unit idle and able to accept.
- i_mem_rden  in  1  load request.
- i_mem_wren  in  1  store request.
- i_w_b_LSU  in  1  1 = byte access, 0 = word access.
- i_l_unsigned  in  1  byte load zero-extends when 1.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data; byte stores use [7:0].
- o_stall  out  1  freeze the pipeline while the op is outstanding.
- o_rdata  out  32  formatted load data.
- o_rdata_vld  out  1  one-cycle load-result strobe.
- o_misalign  out  1  one-cycle strobe for a rejected misaligned word access.
- o_timeout  out  1  one-cycle strobe when the ack wait expires.
- o_dmem_req  out  1  memory request, held until ack or timeout.
- o_dmem_we  out  1  1 = write.
- o_dmem_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 0.
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  32  write data.
- i_dmem_ack  in  1  memory completed the request; single-cycle pulse.
- i_dmem_rdata  in  32  read data, valid in the ack cycle.

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset (asynchronous): state = IDLE, timeout counter = 0, o_rdata = 0. All outputs are 0, including o_lsu_rdy, while i_rst_n is low.
- o_lsu_rdy = (state == IDLE) when out of reset.
- Accept condition: IDLE & i_lsu_vld & (i_mem_rden | i_mem_wren).
  - If both rden and wren are set, the op is a store (wren has priority).
- Misaligned op: word access (i_w_b_LSU = 0) with i_addr[1:0] != 0.
  - No memory access; FSM stays in IDLE.
  - o_misalign pulses the next cycle.
  - o_stall stays 0.
- Accept cycle T:
  - Register address, byte lane (i_addr[1:0]), byte flag, unsigned flag, we and wdata.
  - Go to REQ.
  - o_stall = 1 combinationally in cycle T.
- REQ state:
  - o_dmem_req = 1; addr, we, be and wdata held stable.
  - o_stall = 1.
  - Counter increments each cycle.
  - A load ack registers the formatted data; an ack with either op goes to DONE.
  - An ack in the first REQ cycle (T+1) is legal, giving minimum total latency 2 cycles: accept T, ack T+1, DONE T+2.
- Timeout: in REQ, when TIMEOUT_CYC != 0, the counter reaches TIMEOUT_CYC, and there is no ack:
  - Drop req.
  - Go to DONE with o_timeout = 1.
  - A load returns o_rdata = 0 with o_rdata_vld = 1.
  - An ack in the same cycle as expiry wins; no timeout is raised.
- DONE state, one cycle:
  - o_stall = 0.
  - o_rdata_vld = 1 for loads.
  - o_timeout as above.
  - Return to IDLE. No accept in DONE, so back-to-back ops are spaced by at least 3 cycles.
- Byte enables and write data:
  - Word: be = 4'hF, wdata = i_wdata.
  - Byte: be = 4'b0001 << lane, wdata = {4{i_wdata[7:0]}}.
- Load formatting:
  - Word: i_dmem_rdata.
  - Byte: selected byte = i_dmem_rdata[8*lane +: 8], then zero-extended if unsigned, otherwise sign-extended from bit 7.
- i_dmem_ack outside REQ is ignored.
- Counter clears on accept.
- o_rdata holds its value until the next load completes.
- Reset mid-REQ aborts immediately: req drops asynchronously and no strobes are produced.

Test Plan:
- LW at 0x10, ack at T+3 with rdata 0xDEADBEEF -> req high T+1..T+3, be = F, o_dmem_addr = 0x10; DONE at T+4 with o_rdata = 0xDEADBEEF, o_rdata_vld = 1; o_stall high T..T+3.
- LB at 0x13, rdata 0x80112233 -> be = 4'b1000 lane 3, o_rdata = 0xFFFFFF80; LBU same access -> 0x00000080.
- SB wdata 0x000000A5 at 0x21 -> o_dmem_addr = 0x20, be = 4'b0010, o_dmem_wdata = 0xA5A5A5A5, o_dmem_we = 1; no o_rdata_vld.
- LW at 0x06 -> o_misalign single pulse, o_dmem_req never asserted, o_stall = 0, o_lsu_rdy stays 1.
- TIMEOUT_CYC = 4, load with ack withheld -> req for 4 cycles, then o_timeout = 1, o_rdata_vld = 1, o_rdata = 0. Repeat with ack in the expiry cycle -> real data, no timeout.
- Assert i_rst_n low during REQ -> req, stall and rdy drop immediately; after release FSM is IDLE and the next LW completes normally.
